counter_sequencer: RTL and testbench
====================================

# counter_sequencer

Sweep controller for the 8-bit up/down `counter`. It drives the counter's `enable` and `up_down` inputs and watches its `count` output. On a start request it moves the counter to a programmed floor, then runs repeated floor→ceiling→floor sweeps with programmable dwell at each end. It reports busy/done/error status to the host control logic.

## Interface
- `WIDTH`, default 8: counter width; must match the counter instance.
- `DWELL_W`, default 8: width of the dwell configuration.
- `REP_W`, default 8: width of the repetition count.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  sweep request; sampled only in IDLE.
- `abort`  in  1  stop immediately; priority over `start`.
- `cfg_lo`  in  WIDTH  sweep floor; latched on accepted start.
- `cfg_hi`  in  WIDTH  sweep ceiling; latched on accepted start.
- `cfg_dwell`  in  DWELL_W  extra hold cycles at each end; latched on accepted start.
- `cfg_reps`  in  REP_W  number of up/down sweeps; latched on accepted start.
- `count_in`  in  WIDTH  counter `count` output.
- `cnt_enable`  out  1  to counter `enable`; registered.
- `cnt_up_down`  out  1  to counter `up_down` (1 = up); registered.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse on normal completion.
- `err`  out  1  one-cycle pulse on rejected configuration.
- `phase`  out  3  current state encoding.
- `reps_left`  out  REP_W  remaining sweeps.

## Operation
- Counter model: when enabled, the count steps ±1 per clock; it is registered, with no lookahead.
- Reset values: `cnt_enable` 0, `cnt_up_down` 1, `busy` 0, `done` 0, `err` 0, `phase` 0 (IDLE), `reps_left` 0.
- States: IDLE=0, SEEK=1, UP=2, DWELL_HI=3, DOWN=4, DWELL_LO=5.
- IDLE, `start`=1:
  - If `cfg_hi` ≤ `cfg_lo` or `cfg_reps`=0: pulse `err` and stay in IDLE.
  - Otherwise latch the configuration, set `busy`, and load `reps_left` with `cfg_reps`.
  - If `count_in`≠`cfg_lo`, go to SEEK: `cnt_enable`←1, direction toward lo. Else go to DWELL_LO.
- SEEK:
  - Direction up: terminates on `count_in` ≥ lo−1 with `cnt_enable`=1.
  - Direction down: terminates on `count_in` ≤ lo+1 with `cnt_enable`=1.
  - At the terminating edge: `cnt_enable`←0, go to DWELL_LO.
- UP (`cnt_up_down`=1): terminates on `count_in` ≥ hi−1 with `cnt_enable`=1. Then `cnt_enable`←0 and go to DWELL_HI.
- DWELL_HI: lasts `cfg_dwell`+1 cycles with `cnt_enable`=0. Exit edge: `cnt_enable`←1, `cnt_up_down`←0, go to DOWN.
- DOWN: terminates on `count_in` ≤ lo+1 with `cnt_enable`=1. At the terminating edge: `cnt_enable`←0 and decrement `reps_left`.
  - New value 0: go to IDLE, `busy`←0, `done`←1.
  - Otherwise: go to DWELL_LO.
- DWELL_LO: lasts `cfg_dwell`+1 cycles with `cnt_enable`=0. Exit edge: `cnt_enable`←1, `cnt_up_down`←1, go to UP.
- `cnt_up_down` holds its last value whenever `cnt_enable`=0.
- `abort` in any non-IDLE state: at the next edge `cnt_enable`←0, go to IDLE, `busy`←0, `reps_left`←0. No `done`, no `err`.
- `start` while busy: ignored.
- Relational compares bound the run if `count_in` is disturbed externally (e.g. the counter is reset mid-sweep): at most one step of overshoot, never an unbounded run.
- `rst` mid-sweep: all outputs return to their reset values immediately.

## Timing
- Start accepted at edge E0: `busy` is high from E0.
- The count reaches each endpoint exactly; no overshoot in normal operation.
- Endpoint hold: each endpoint value is held for `cfg_dwell`+2 cycles (dwell state plus the re-enable cycle).
- `done`: high for exactly one cycle, starting at the edge the final lo is reached. `busy` falls at that same edge.
- `err`: high for exactly one cycle, starting at the edge after the rejected `start`.
- Abort latency: one edge.

## Structure
- Package `counter_seq_pkg` holds:
  - the phase enum and its encodings;
  - default widths `WIDTH`, `DWELL_W`, `REP_W`.
- Sub-module `seq_dwell_timer`: loadable down-counter with a `load`/`expire` interface, shared by DWELL_HI and DWELL_LO.
- The top-level FSM is kept in `counter_sequencer`.

## Test plan
- Basic sweep: `count_in` starts at 0; lo=2, hi=5, dwell=0, reps=1; start at E0. Required: count runs 0→2, holds 2 for 2 cycles, runs →5, holds 5 for 2 cycles, runs →2. `done` pulses at E10; `busy` is high over [E0,E10).
- Repeated sweeps: lo=10, hi=12, dwell=3, reps=3, count already 10. Required: no SEEK; each endpoint held 5 cycles; `reps_left` steps 3→2→1→0; exactly one `done`.
- Seek down: count=200, lo=50, hi=60, dwell=0, reps=1. Required: `cnt_up_down`=0 during SEEK; first UP starts from exactly 50.
- Bad configuration: hi=lo=7 → one `err` pulse, `busy` stays 0. Separately, reps=0 → one `err` pulse.
- Abort mid-UP at count=40: `cnt_enable`=0 at the next edge, count frozen at 41 or lower, phase=0, no `done`. A new `start` is then accepted.
- Reset: `rst` pulsed mid-DOWN → every output takes its reset value asynchronously. `start` during busy → no effect on `reps_left` or the latched configuration.

Source files
------------

// File: rtl/counter_sequencer_pkg.sv
// Shared phase encoding and default widths for the counter sweep sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package counter_seq_pkg;

   localparam int WIDTH   = 8;
   localparam int DWELL_W = 8;
   localparam int REP_W   = 8;

   // Encodings are visible to the host through the phase output; keep them stable.
   typedef enum logic [2:0] {
      PH_IDLE     = 3'd0,
      PH_SEEK     = 3'd1,
      PH_UP       = 3'd2,
      PH_DWELL_HI = 3'd3,
      PH_DOWN     = 3'd4,
      PH_DWELL_LO = 3'd5
   } phase_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Host control, counter hookup and status bundle for the sweep sequencer.
// Latency: none (wiring only).
// Backpressure: none; start is a level sampled only while idle.
interface counter_sequencer_if #(
   parameter int WIDTH   = counter_seq_pkg::WIDTH,
   parameter int DWELL_W = counter_seq_pkg::DWELL_W,
   parameter int REP_W   = counter_seq_pkg::REP_W
);
   logic               start;
   logic               abort;
   logic [WIDTH-1:0]   cfg_lo;
   logic [WIDTH-1:0]   cfg_hi;
   logic [DWELL_W-1:0] cfg_dwell;
   logic [REP_W-1:0]   cfg_reps;
   logic [WIDTH-1:0]   count_in;
   logic               cnt_enable;
   logic               cnt_up_down;
   logic               busy;
   logic               done;
   logic               err;
   logic [2:0]         phase;
   logic [REP_W-1:0]   reps_left;

   // Host / environment side: drives requests, config and the observed count.
   modport master (
      output start, abort, cfg_lo, cfg_hi, cfg_dwell, cfg_reps, count_in,
      input  cnt_enable, cnt_up_down, busy, done, err, phase, reps_left
   );

   // Sequencer side.
   modport slave (
      input  start, abort, cfg_lo, cfg_hi, cfg_dwell, cfg_reps, count_in,
      output cnt_enable, cnt_up_down, busy, done, err, phase, reps_left
   );
endinterface

// File: rtl/counter_sequencer_dwell_timer.sv
// Loadable down-counter timing the hold at either sweep endpoint.
// Latency: expire rises load_val cycles after the load edge (same cycle if 0).
// Backpressure: none; a load always restarts the count.
module seq_dwell_timer #(
   parameter int DWELL_W = counter_seq_pkg::DWELL_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_val,
   output logic               expire
);
   logic [DWELL_W-1:0] remain;

   // Count down to zero after each load and park there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         remain <= '0;
      else if (load)
         remain <= load_val;
      else if (remain != '0)
         remain <= remain - DWELL_W'(1);
   end

   // A load in flight masks a stale zero from the previous hold.
   assign expire = (remain == '0) && !load;
endmodule

// File: rtl/counter_sequencer.sv
// Drives an external up/down counter through seek + repeated lo->hi->lo sweeps.
// Latency: outputs registered; abort and start take effect at the next edge.
// Backpressure: start ignored while busy; abort always wins over start.
module counter_sequencer #(
   parameter int WIDTH   = counter_seq_pkg::WIDTH,
   parameter int DWELL_W = counter_seq_pkg::DWELL_W,
   parameter int REP_W   = counter_seq_pkg::REP_W
) (
   input  logic           clk,
   input  logic           rst,
   counter_sequencer_if.slave bus
);
   import counter_seq_pkg::*;

   phase_t             state_q, state_d;
   logic               en_q, en_d;
   logic               ud_q, ud_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic [REP_W-1:0]   reps_q, reps_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;

   logic               tmr_load;
   logic [DWELL_W-1:0] tmr_val;
   logic               tmr_expire;

   // Endpoints are compared one step early because the counter output is
   // registered: seeing lo-1 / hi-1 with enable high means the step now
   // landing is the last one. Relational compares cap any overshoot at one
   // step if the count is disturbed. hi > lo guarantees none of these wrap
   // in the direction where they are used.
   logic [WIDTH-1:0] lo_m1, lo_p1, hi_m1;
   assign lo_m1 = lo_q - WIDTH'(1);
   assign lo_p1 = lo_q + WIDTH'(1);
   assign hi_m1 = hi_q - WIDTH'(1);

   seq_dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expire   (tmr_expire)
   );

   // State and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= PH_IDLE;
         en_q    <= 1'b0;
         ud_q    <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         reps_q  <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         ud_q    <= ud_d;
         done_q  <= done_d;
         err_q   <= err_d;
         reps_q  <= reps_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dwell_q <= dwell_d;
      end
   end

   // Next-state and next-output logic; pulses default low every cycle.
   always_comb begin
      state_d  = state_q;
      en_d     = en_q;
      ud_d     = ud_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      reps_d   = reps_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      dwell_d  = dwell_q;
      tmr_load = 1'b0;
      tmr_val  = dwell_q;

      if (state_q != PH_IDLE && bus.abort) begin
         state_d = PH_IDLE;
         en_d    = 1'b0;
         reps_d  = '0;
      end else begin
         case (state_q)
            PH_IDLE: begin
               if (bus.start && !bus.abort) begin
                  if (bus.cfg_hi <= bus.cfg_lo || bus.cfg_reps == '0) begin
                     err_d = 1'b1;
                  end else begin
                     lo_d    = bus.cfg_lo;
                     hi_d    = bus.cfg_hi;
                     dwell_d = bus.cfg_dwell;
                     reps_d  = bus.cfg_reps;
                     if (bus.count_in != bus.cfg_lo) begin
                        state_d = PH_SEEK;
                        en_d    = 1'b1;
                        ud_d    = (bus.count_in < bus.cfg_lo);
                     end else begin
                        // Already at the floor: go straight to the low hold.
                        state_d  = PH_DWELL_LO;
                        tmr_load = 1'b1;
                        tmr_val  = bus.cfg_dwell;
                     end
                  end
               end
            end
            PH_SEEK: begin
               if (en_q && ((ud_q && bus.count_in >= lo_m1) ||
                            (!ud_q && bus.count_in <= lo_p1))) begin
                  en_d     = 1'b0;
                  state_d  = PH_DWELL_LO;
                  tmr_load = 1'b1;
               end
            end
            PH_UP: begin
               if (en_q && bus.count_in >= hi_m1) begin
                  en_d     = 1'b0;
                  state_d  = PH_DWELL_HI;
                  tmr_load = 1'b1;
               end
            end
            PH_DWELL_HI: begin
               if (tmr_expire) begin
                  en_d    = 1'b1;
                  ud_d    = 1'b0;
                  state_d = PH_DOWN;
               end
            end
            PH_DOWN: begin
               if (en_q && bus.count_in <= lo_p1) begin
                  en_d   = 1'b0;
                  reps_d = reps_q - REP_W'(1);
                  if (reps_q == REP_W'(1)) begin
                     state_d = PH_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d  = PH_DWELL_LO;
                     tmr_load = 1'b1;
                  end
               end
            end
            PH_DWELL_LO: begin
               if (tmr_expire) begin
                  en_d    = 1'b1;
                  ud_d    = 1'b1;
                  state_d = PH_UP;
               end
            end
            default: begin
               state_d = PH_IDLE;
               en_d    = 1'b0;
            end
         endcase
      end
   end

   assign bus.cnt_enable  = en_q;
   assign bus.cnt_up_down = ud_q;
   assign bus.busy        = (state_q != PH_IDLE);
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.phase       = state_q;
   assign bus.reps_left   = reps_q;
endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural sweep model.
// Latency: model indexed by edges after the accepting edge E0.
// Backpressure: not applicable.
module tb_counter_sequencer;
   localparam int W  = 8;
   localparam int DW = 8;
   localparam int RW = 8;

   localparam int P_IDLE = 0, P_SEEK = 1, P_UP = 2, P_DHI = 3, P_DOWN = 4, P_DLO = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   counter_sequencer_if #(.WIDTH(W), .DWELL_W(DW), .REP_W(RW)) bus ();

   counter_sequencer #(.WIDTH(W), .DWELL_W(DW), .REP_W(RW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Environment counter: registered, steps +-1 when enabled, loadable by bench.
   logic [W-1:0] count = '0;
   logic         cnt_load = 1'b0;
   logic [W-1:0] cnt_load_val = '0;
   always @(posedge clk) begin
      if (cnt_load)
         count <= cnt_load_val;
      else if (bus.cnt_enable)
         count <= bus.cnt_up_down ? count + 8'd1 : count - 8'd1;
   end
   assign bus.count_in = count;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Expected per-edge trace, index k = state after edge Ek.
   int exp_cnt[$];
   int exp_ph[$];
   int exp_rl[$];
   int exp_dn[$];

   task automatic push(input int c, input int ph, input int rl, input int dn);
      exp_cnt.push_back(c);
      exp_ph.push_back(ph);
      exp_rl.push_back(rl);
      exp_dn.push_back(dn);
   endtask

   // Trace from the sweep rules: walk to lo, hold each end dwell+2 cycles
   // (arrival + dwell + exit cycle), run reps round trips, done on final lo.
   task automatic build_model(input int c0, input int lo, input int hi,
                              input int dwell, input int reps);
      int cur;
      int rl;
      exp_cnt.delete(); exp_ph.delete(); exp_rl.delete(); exp_dn.delete();
      cur = c0;
      rl  = reps;
      if (cur != lo) begin
         push(cur, P_SEEK, rl, 0);
         while (cur != lo) begin
            cur += (lo > cur) ? 1 : -1;
            push(cur, (cur == lo) ? P_DLO : P_SEEK, rl, 0);
         end
      end else begin
         push(cur, P_DLO, rl, 0);
      end
      repeat (dwell) push(lo, P_DLO, rl, 0);
      push(lo, P_UP, rl, 0);
      for (int r = 1; r <= reps; r++) begin
         while (cur != hi) begin
            cur++;
            push(cur, (cur == hi) ? P_DHI : P_UP, rl, 0);
         end
         repeat (dwell) push(hi, P_DHI, rl, 0);
         push(hi, P_DOWN, rl, 0);
         while (cur != lo) begin
            cur--;
            if (cur == lo) begin
               rl--;
               if (rl == 0) push(cur, P_IDLE, rl, 1);
               else         push(cur, P_DLO, rl, 0);
            end else begin
               push(cur, P_DOWN, rl, 0);
            end
         end
         if (rl != 0) begin
            repeat (dwell) push(lo, P_DLO, rl, 0);
            push(lo, P_UP, rl, 0);
         end
      end
   endtask

   int chk_idx = 0;
   bit chk_on  = 1'b0;

   // Compare process: one model step per edge, sampled 1 time unit after it.
   always @(posedge clk) begin
      int k, cur, nxt, last;
      #1;
      if (chk_on) begin
         k    = chk_idx;
         last = exp_cnt.size() - 1;
         cur  = exp_cnt[k];
         nxt  = (k < last) ? exp_cnt[k+1] : cur;
         check("count",       int'(count),           cur);
         check("phase",       int'(bus.phase),       exp_ph[k]);
         check("reps_left",   int'(bus.reps_left),   exp_rl[k]);
         check("done",        int'(bus.done),        exp_dn[k]);
         check("busy",        int'(bus.busy),        (k < last) ? 1 : 0);
         check("err",         int'(bus.err),         0);
         check("cnt_enable",  int'(bus.cnt_enable),  (nxt != cur) ? 1 : 0);
         if (nxt != cur)
            check("cnt_up_down", int'(bus.cnt_up_down), (nxt > cur) ? 1 : 0);
         chk_idx++;
         if (chk_idx == exp_cnt.size()) chk_on = 1'b0;
      end
   end

   task automatic load_counter(input int v);
      @(negedge clk);
      cnt_load     = 1'b1;
      cnt_load_val = W'(v);
      @(negedge clk);
      cnt_load     = 1'b0;
   endtask

   task automatic set_cfg(input int lo, input int hi, input int dwell, input int reps);
      bus.cfg_lo    = W'(lo);
      bus.cfg_hi    = W'(hi);
      bus.cfg_dwell = DW'(dwell);
      bus.cfg_reps  = RW'(reps);
   endtask

   // Start a sweep against the model; optionally poke start mid-run.
   task automatic run_sweep(input int c0, input int lo, input int hi,
                            input int dwell, input int reps, input bit poke);
      load_counter(c0);
      build_model(c0, lo, hi, dwell, reps);
      set_cfg(lo, hi, dwell, reps);
      bus.start = 1'b1;
      chk_idx   = 0;
      chk_on    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      if (poke) begin
         repeat (6) @(negedge clk);
         set_cfg(0, 255, 0, 9);
         bus.start = 1'b1;
         @(negedge clk);
         bus.start = 1'b0;
      end
      for (int i = 0; i < 2000 && chk_on; i++) @(negedge clk);
      if (chk_on) begin
         check("sweep_timeout", 1, 0);
         chk_on = 1'b0;
      end
      @(posedge clk); #1;
      check("done_after", int'(bus.done), 0);
      check("busy_after", int'(bus.busy), 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_cnt_enable"},  int'(bus.cnt_enable),  0);
      check({tag, "_cnt_up_down"}, int'(bus.cnt_up_down), 1);
      check({tag, "_busy"},        int'(bus.busy),        0);
      check({tag, "_done"},        int'(bus.done),        0);
      check({tag, "_err"},         int'(bus.err),         0);
      check({tag, "_phase"},       int'(bus.phase),       0);
      check({tag, "_reps_left"},   int'(bus.reps_left),   0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      set_cfg(0, 0, 0, 0);
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Basic sweep; pin the model against hand-derived points first.
      build_model(0, 2, 5, 0, 1);
      check("model_basic_len",  exp_cnt.size(), 11);
      check("model_basic_e3",   exp_cnt[3], 2);
      check("model_basic_e7",   exp_cnt[7], 5);
      check("model_basic_done", exp_dn[10], 1);
      run_sweep(0, 2, 5, 0, 1, 1'b0);

      // Repeated sweeps from the floor, with a start poked while busy.
      build_model(10, 10, 12, 3, 3);
      check("model_rep_len", exp_cnt.size(), 37);
      check("model_rep_e4",  exp_ph[4], P_UP);
      check("model_rep_rl",  exp_rl[20], 2);
      run_sweep(10, 10, 12, 3, 3, 1'b1);

      // Seek downward to the floor.
      build_model(200, 50, 60, 0, 1);
      check("model_seek_len", exp_cnt.size(), 173);
      run_sweep(200, 50, 60, 0, 1, 1'b0);

      // Rejected configurations: hi == lo, then reps == 0.
      @(negedge clk);
      set_cfg(7, 7, 0, 1);
      bus.start = 1'b1;
      @(posedge clk); #1;
      check("err_eq_pulse", int'(bus.err),  1);
      check("err_eq_busy",  int'(bus.busy), 0);
      check("err_eq_phase", int'(bus.phase), 0);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("err_eq_clear", int'(bus.err), 0);
      @(negedge clk);
      set_cfg(3, 9, 0, 0);
      bus.start = 1'b1;
      @(posedge clk); #1;
      check("err_reps_pulse", int'(bus.err),  1);
      check("err_reps_busy",  int'(bus.busy), 0);
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("err_reps_clear", int'(bus.err), 0);

      // Abort mid-UP with count at 40.
      load_counter(30);
      set_cfg(30, 60, 0, 1);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (count == 8'd40 && bus.phase == 3'd2) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("abort_reach40", int'(found), 1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      check("abort_enable", int'(bus.cnt_enable), 0);
      check("abort_phase",  int'(bus.phase),      0);
      check("abort_busy",   int'(bus.busy),       0);
      check("abort_reps",   int'(bus.reps_left),  0);
      check("abort_done",   int'(bus.done),       0);
      check("abort_count",  int'(count),          41);
      @(negedge clk);
      bus.abort = 1'b0;
      @(posedge clk); #1;
      check("abort_frozen", int'(count),    41);
      check("abort_nodone", int'(bus.done), 0);

      // Fresh start after abort: seek up, dwell 1, two round trips.
      run_sweep(41, 45, 47, 1, 2, 1'b0);

      // Asynchronous reset in the middle of DOWN.
      load_counter(0);
      set_cfg(5, 9, 0, 2);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.phase == 3'd4) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_reach_down", int'(found), 1);
      #2 rst = 1'b1;
      #1;
      check_reset_values("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_phase", int'(bus.phase), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
